// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: merges hazard, fetch-wait, data-wait and mul/div events.
// Latency: Stall*/Flush* are combinational from state and inputs (0 cycles); state is registered.
// Backpressure: data wait holds F/D/E/M, mul/div holds F/D/E; optional PIPE_CTRL_PERF_EN adds counters.
module pipe_ctrl #(
  parameter int MDIV_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lwStall,
  input  logic             PCSrc_E,
  input  logic             MulDivStart_E,
  input  logic             MulDivDone_E,
  input  logic             IMemReady_F,
  input  logic             DMemReq_M,
  input  logic             DMemReady_M,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             MDivTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int TW = $clog2(MDIV_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(MDIV_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_MDIV  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          redir_pend_q, redir_pend_d;
  logic [TW-1:0] mdiv_cnt_q, mdiv_cnt_d;
  logic          mdiv_to_q, mdiv_to_d;
  // Set by reset and cleared by the first clock edge afterwards; keeps the
  // pipeline flushed until the clock has actually started running.
  logic          init_q, init_d;

  logic dmem_wait;
  logic mdiv_exit;
  logic mdiv_timed_out;
  logic rule_data;
  logic rule_mdiv;
  logic redir_set;

  // Event decode shared by the output and next-state logic.
  always_comb begin
    dmem_wait      = DMemReq_M & ~DMemReady_M;
    mdiv_timed_out = (mdiv_cnt_q == TO_LAST);
    // The timeout cycle releases the pipe exactly like a done cycle.
    mdiv_exit      = MulDivDone_E | mdiv_timed_out;
    rule_data      = ~init_q & (((state_q == ST_DWAIT) & ~DMemReady_M) |
                                ((state_q == ST_RUN) & dmem_wait));
    rule_mdiv      = ~init_q & (((state_q == ST_MDIV) & ~mdiv_exit) |
                                ((state_q == ST_RUN) & MulDivStart_E));
    // A redirect only counts once E is free; otherwise the branch re-resolves later.
    redir_set      = ~init_q & ~rule_data & ~rule_mdiv & PCSrc_E & ~IMemReady_F;
  end

  // Priority-resolved stall/flush enables; only the highest active rule drives.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    if (init_q) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (rule_data) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (rule_mdiv) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrc_E) begin
        // Redirect beats a same-cycle load-use: the dependent op is squashed.
        FlushD = 1'b1;
        FlushE = 1'b1;
        StallF = ~IMemReady_F;
      end else if (lwStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (!IMemReady_F) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end
      // The wrong-path fetch still in flight is dropped, including on its completion cycle.
      if (redir_pend_q) begin
        FlushD = 1'b1;
      end
    end
  end

  // Next-state logic for the sequencer, redirect tracking and mul/div watchdog.
  always_comb begin
    state_d      = state_q;
    redir_pend_d = redir_pend_q;
    mdiv_cnt_d   = '0;
    mdiv_to_d    = mdiv_to_q;
    init_d       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_wait) begin
          state_d = ST_DWAIT;
        end else if (MulDivStart_E) begin
          state_d = ST_MDIV;
        end
      end
      ST_DWAIT: begin
        if (DMemReady_M) begin
          state_d = ST_RUN;
        end
      end
      ST_MDIV: begin
        if (mdiv_exit) begin
          state_d = ST_RUN;
        end else begin
          mdiv_cnt_d = mdiv_cnt_q + TO_ONE;
        end
        if (mdiv_timed_out && !MulDivDone_E) begin
          mdiv_to_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (IMemReady_F) begin
      redir_pend_d = 1'b0;
    end else if (redir_set) begin
      redir_pend_d = 1'b1;
    end

    if (init_q) begin
      state_d    = ST_RUN;
      mdiv_cnt_d = '0;
      mdiv_to_d  = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      mdiv_cnt_q   <= '0;
      mdiv_to_q    <= 1'b0;
      init_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      mdiv_cnt_q   <= mdiv_cnt_d;
      mdiv_to_q    <= mdiv_to_d;
      init_q       <= init_d;
    end
  end

  assign MDivTimeout = mdiv_to_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Free-running event counters; they wrap naturally at 2^CNT_W.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!init_q && StallF) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end
    if (!init_q && FlushE) begin
      flush_count_d = flush_count_q + CNT_ONE;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed cycles push expected enables to a queue,
// the value is popped and compared on the falling edge of the same cycle.
// Counter expectations are tallied from the expected enables.
module tb_pipe_ctrl;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lwStall = 1'b0, PCSrc_E = 1'b0, MulDivStart_E = 1'b0, MulDivDone_E = 1'b0;
  logic IMemReady_F = 1'b1, DMemReq_M = 1'b0, DMemReady_M = 1'b0;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
  logic MDivTimeout;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  always #5 clk = ~clk;

  pipe_ctrl #(.MDIV_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lwStall(lwStall), .PCSrc_E(PCSrc_E),
    .MulDivStart_E(MulDivStart_E), .MulDivDone_E(MulDivDone_E),
    .IMemReady_F(IMemReady_F), .DMemReq_M(DMemReq_M), .DMemReady_M(DMemReady_M),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .MDivTimeout(MDivTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  // Enable vector: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_RST  = 8'b0000_1111;
  localparam logic [7:0] E_DW   = 8'b1111_0001;
  localparam logic [7:0] E_MD   = 8'b1110_0010;
  localparam logic [7:0] E_MDP  = 8'b1110_1010;
  localparam logic [7:0] E_LU   = 8'b1100_0100;
  localparam logic [7:0] E_RD   = 8'b0000_1100;
  localparam logic [7:0] E_RDS  = 8'b1000_1100;
  localparam logic [7:0] E_FW   = 8'b1000_1000;
  localparam logic [7:0] E_PEND = 8'b0000_1000;

  // Input vector: {lwStall,PCSrc_E,MulDivStart_E,MulDivDone_E,IMemReady_F,DMemReq_M,DMemReady_M}
  localparam logic [6:0] I_IDLE   = 7'b0000100;
  localparam logic [6:0] I_NF     = 7'b0000000;
  localparam logic [6:0] I_LW     = 7'b1000100;
  localparam logic [6:0] I_LWNF   = 7'b1000000;
  localparam logic [6:0] I_LWPC   = 7'b1100100;
  localparam logic [6:0] I_PC     = 7'b0100100;
  localparam logic [6:0] I_PCNF   = 7'b0100000;
  localparam logic [6:0] I_MS     = 7'b0010100;
  localparam logic [6:0] I_MSNF   = 7'b0010000;
  localparam logic [6:0] I_MD     = 7'b0001100;
  localparam logic [6:0] I_DWMS   = 7'b0010110;
  localparam logic [6:0] I_DWPCNF = 7'b0110010;
  localparam logic [6:0] I_DRDY   = 7'b0000111;
  localparam logic [6:0] I_DRDYMS = 7'b0010111;
  localparam logic [6:0] I_DRLWNF = 7'b1000011;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [7:0] exp_q[$];

  wire [7:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare mid-cycle.
  task automatic step(input logic [6:0] in, input logic [7:0] exp, input string tag);
    logic [7:0] want;
    {lwStall, PCSrc_E, MulDivStart_E, MulDivDone_E, IMemReady_F, DMemReq_M, DMemReady_M} = in;
    exp_q.push_back(exp);
    if (rst_n && exp != E_RST) begin
      exp_stall += int'(exp[7]);
      exp_flush += int'(exp[2]);
    end
    @(negedge clk);
    want = exp_q.pop_front();
    check(tag, {24'd0, ctl}, {24'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic perf_check(input string tag);
`ifdef PIPE_CTRL_PERF_EN
    check({tag, "_stallcyc"}, StallCycles, exp_stall);
    check({tag, "_flushcnt"}, FlushCount, exp_flush);
`else
    check({tag, "_stallcyc"}, StallCycles, 32'd0);
    check({tag, "_flushcnt"}, FlushCount, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    step(I_IDLE, E_RST, "rst_low");
    check("rst_timeout", {31'd0, MDivTimeout}, 32'd0);
    perf_check("rst");
    rst_n = 1'b1;
    step(I_IDLE, E_RST, "rst_release");
  endtask

  initial begin
    #1;
    // Reset and idle
    do_reset();
    for (int i = 0; i < 3; i++) step(I_IDLE, E_NONE, "idle");

    // Load-use, redirect, fetch wait
    step(I_LW,   E_LU,   "lw");
    step(I_IDLE, E_NONE, "lw_after");
    step(I_LWPC, E_RD,   "lw_pc");
    step(I_IDLE, E_NONE, "lw_pc_after");
    step(I_LWNF, E_LU,   "lw_nofetch");
    step(I_NF,   E_FW,   "fetch_wait");
    step(I_IDLE, E_NONE, "fw_after");
    perf_check("hz");

    // Mul/div completing after 5 cycles, with a branch ignored while E is held
    step(I_MS,   E_MD,   "md_start");
    step(I_IDLE, E_MD,   "md_busy");
    step(I_PC,   E_MD,   "md_pc_ignored");
    step(I_IDLE, E_MD,   "md_busy");
    step(I_IDLE, E_MD,   "md_busy");
    step(I_MD,   E_NONE, "md_done");
    step(I_IDLE, E_NONE, "md_after");
    check("md_timeout", {31'd0, MDivTimeout}, 32'd0);

    // Mul/div never completes: forced exit after 64 stalled cycles
    step(I_MS, E_MD, "to_start");
    for (int i = 0; i < 63; i++) step(I_IDLE, E_MD, "to_stall");
    check("to_pre_flag", {31'd0, MDivTimeout}, 32'd0);
    step(I_IDLE, E_NONE, "to_exit");
    check("to_flag", {31'd0, MDivTimeout}, 32'd1);
    step(I_IDLE, E_NONE, "to_run");
    step(I_MS,   E_MD,   "to_again_start");
    step(I_MD,   E_NONE, "to_again_done");
    check("to_sticky", {31'd0, MDivTimeout}, 32'd1);
    perf_check("md");

    // Data wait beats mul/div start; start dropped before release
    for (int i = 0; i < 3; i++) step(I_DWMS, E_DW, "dw_ms");
    step(I_DRDY, E_NONE, "dw_release");
    step(I_IDLE, E_NONE, "dw_no_mdiv");

    // Data wait with start still held at release: MDIV follows
    for (int i = 0; i < 3; i++) step(I_DWMS, E_DW, "dw_ms_hold");
    step(I_DRDYMS, E_NONE, "dw_release_ms");
    step(I_MS,     E_MD,   "dw_then_mdiv");
    step(I_MD,     E_NONE, "dw_mdiv_done");

    // Branch during data wait does not leave a pending redirect
    step(I_DWMS,   E_DW,   "dw_pc_a");
    step(I_DWPCNF, E_DW,   "dw_pc_ignored");
    step(I_DWMS,   E_DW,   "dw_pc_b");
    step(I_DRLWNF, E_LU,   "dw_pc_release_lw");
    step(I_IDLE,   E_NONE, "dw_pc_after");
    perf_check("dw");

    // Reset taken mid-MDIV with a redirect pending
    step(I_PCNF, E_RDS, "pend_set");
    step(I_MSNF, E_MDP, "pend_mdiv");
    do_reset();
    step(I_LWNF, E_LU,   "post_rst_lw");
    step(I_IDLE, E_NONE, "post_rst_idle");
    perf_check("post_rst");

    // Redirect with a 4-cycle fetch wait
    do_reset();
    step(I_PCNF, E_RDS,  "rd_start");
    for (int i = 0; i < 3; i++) step(I_NF, E_FW, "rd_wait");
    step(I_IDLE, E_PEND, "rd_fetch_done");
    step(I_IDLE, E_NONE, "rd_after");
    perf_check("rd");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV64I pipeline. It merges per-cycle hazard requests with multi-cycle events: instruction-memory wait, data-memory wait and multi-cycle execute ops (mul/div). It then drives one consistent set of per-stage Stall*/Flush* enables to the pipeline registers. The load-use and forwarding detector stays combinational and feeds this block, which owns all sequencing and priority.

Parameters:
MDIV_TIMEOUT, 64, max cycles in MDIV before forced exit (≥2)
CNT_W, 32, width of optional performance counters

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
lwStall  in  1  load-use stall request from the hazard detector
PCSrc_E  in  1  taken branch/jump resolved in Execute
MulDivStart_E  in  1  multi-cycle op valid in Execute (single-cycle pulse)
MulDivDone_E  in  1  multi-cycle unit result ready
IMemReady_F  in  1  instruction fetch completes this cycle
DMemReq_M  in  1  load/store active in Memory
DMemReady_M  in  1  data access completes this cycle
StallF, StallD, StallE, StallM  out  1 each  hold the stage register
FlushD, FlushE, FlushM, FlushW  out  1 each  insert a bubble into the stage register
MDivTimeout  out  1  sticky error flag
StallCycles  out  CNT_W  optional performance counter
FlushCount  out  CNT_W  optional performance counter

Behaviour:
- Reset (rst_n=0, async): state=RUN, RedirPend=0, timeout counter=0, MDivTimeout=0, counters=0.
- Outputs during reset: all Stall*=0; FlushD/E/M/W=1. Outputs are released on the first clk edge after rst_n rises.
- State is registered. Stall/Flush outputs are combinational from state, RedirPend and inputs (0-cycle latency).
- State machine states: RUN, DWAIT, MDIV.
- RUN → DWAIT: DMemReq_M & !DMemReady_M.
- RUN → MDIV: MulDivStart_E & !(DMemReq_M & !DMemReady_M).
- DWAIT → RUN: DMemReady_M.
- MDIV → RUN: MulDivDone_E, or the counter reaches MDIV_TIMEOUT-1. On timeout, set MDivTimeout (sticky until reset).
- Per-cycle priority, highest first. Only the highest active rule drives outputs, except where a rule says "additionally".
  1. Data wait (state DWAIT, or RUN with DMemReq_M & !DMemReady_M): StallF/D/E/M=1, FlushW=1.
  2. Multi-cycle (state MDIV and !MulDivDone_E, or RUN with MulDivStart_E): StallF/D/E=1, FlushM=1.
  3. Redirect (PCSrc_E in RUN): FlushD=1, FlushE=1. If IMemReady_F=0, additionally StallF=1 and set RedirPend.
  4. Load-use (lwStall): StallF=1, StallD=1, FlushE=1.
  5. Fetch wait (!IMemReady_F): StallF=1, FlushD=1.
- Rule 2 entered from RUN: in the MulDivStart_E cycle itself the stalls already apply. The counter starts at 0 on entry and increments each MDIV cycle. On the MulDivDone_E cycle, outputs follow RUN rules 3–5.
- RedirPend: while set, FlushD=1 every cycle to discard the in-flight wrong-path fetch. Clears on the cycle IMemReady_F=1, and FlushD is still 1 that cycle.
- PCSrc_E with rule 1 or 2 active is ignored; the branch re-evaluates when E is released.
- Simultaneous lwStall & PCSrc_E: the redirect wins and the load-use stall is dropped. The dependent instruction is flushed.
- rst_n asserted mid-DWAIT/MDIV: immediate return to RUN; RedirPend cleared.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: StallCycles increments each cycle with StallF=1. FlushCount increments on each cycle with FlushE=1. Both wrap at 2^CNT_W and reset to 0.
- Undefined: the counter logic is not instantiated; StallCycles and FlushCount are tied to 0.

Test Plan:
1. Reset, then idle with IMemReady_F=1 and all other inputs 0 → all Stall*/Flush*=0. During rst_n=0 → FlushD/E/M/W=1.
2. lwStall=1 for 1 cycle → StallF=StallD=FlushE=1 that cycle only. lwStall=1 together with PCSrc_E=1 → FlushD=FlushE=1, StallD=0.
3. MulDivStart_E pulse, MulDivDone_E after 5 cycles → StallF/D/E=FlushM=1 for 5 cycles, then 0. MDivTimeout=0.
4. MulDivStart_E with MulDivDone_E never asserted, MDIV_TIMEOUT=64 → return to RUN after 64 stalled cycles; MDivTimeout=1 and stays 1.
5. DMemReq_M=1, DMemReady_M=0 for 3 cycles while MulDivStart_E=1 → StallF/D/E/M=FlushW=1 for 3 cycles (data wait wins), then MDIV only if MulDivStart_E is still held.
6. PCSrc_E=1 with IMemReady_F=0 for 4 cycles → FlushD=1 through the cycle IMemReady_F returns, then 0. With PIPE_CTRL_PERF_EN, FlushCount=1 and StallCycles=4.
